// File: rtl/fpu_seq_pkg.sv
// Shared types and default constants for the FPU fetch/decode/execute sequencer.
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_HALT   = 3'd4
  } seq_state_e;

  localparam logic [31:0] FPU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] FPU_HALT_INSN = 32'h0000_0010;
  localparam int unsigned FPU_PC_INC    = 4;

  function automatic logic seq_is_busy(input seq_state_e s);
    return (s == SEQ_FETCH) || (s == SEQ_DECODE) || (s == SEQ_EXEC);
  endfunction

endpackage

// File: rtl/fpu_seq_wdog.sv
// Clear/count/limit cycle counter guarding the EXEC state of the sequencer.
// Built only when FPU_SEQ_WDOG_EN is defined.
module fpu_seq_wdog #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter value is the number of already elapsed waiting cycles, so the
  // limit is hit during the LIMIT-th counted cycle.
  assign hit_o = count_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !hit_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_fetch_sequencer.sv
// Fetch/decode/execute sequencer for the single-precision FPU core.
// Optional EXEC watchdog enabled by defining FPU_SEQ_WDOG_EN.
module fpu_fetch_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned        PC_W        = 32,
  parameter int unsigned        INSN_W      = 32,
  parameter int unsigned        PC_INC      = FPU_PC_INC,
  parameter logic [PC_W-1:0]    RESET_PC    = PC_W'(FPU_RESET_PC),
  parameter logic [INSN_W-1:0]  HALT_INSN   = INSN_W'(FPU_HALT_INSN),
  parameter int unsigned        CNT_W       = 16,
  parameter int unsigned        WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_rvalid,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic [INSN_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              exec_done,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              exec_timeout
);

  seq_state_e        state_q;
  logic [PC_W-1:0]   pc_q;
  logic [INSN_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              mem_req_q;
  logic              busy_q;
  logic              halted_q;
  logic [CNT_W-1:0]  retired_q;
  logic              wdog_hit;

`ifdef FPU_SEQ_WDOG_EN
  fpu_seq_wdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == SEQ_DECODE),
    .count_i ((state_q == SEQ_EXEC) && !exec_done),
    .hit_o   (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  // The instruction register doubles as instr_out: it is only non-zero
  // during the single DECODE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEQ_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
    end else begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      unique case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            state_q   <= SEQ_FETCH;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SEQ_FETCH: begin
          if (mem_rvalid) begin
            mem_req_q <= 1'b0;
            if (mem_rdata == HALT_INSN) begin
              state_q  <= SEQ_HALT;
              pc_q     <= RESET_PC;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q       <= SEQ_DECODE;
              pc_q          <= pc_q + PC_W'(PC_INC);
              instr_q       <= mem_rdata;
              instr_valid_q <= 1'b1;
            end
          end
        end
        SEQ_DECODE: begin
          state_q <= SEQ_EXEC;
        end
        SEQ_EXEC: begin
          // A completion in the watchdog's limit cycle still retires normally.
          if (exec_done) begin
            retired_q <= retired_q + CNT_W'(1);
            if (start) begin
              state_q   <= SEQ_FETCH;
              mem_req_q <= 1'b1;
            end else begin
              state_q <= SEQ_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (wdog_hit) begin
            state_q <= SEQ_IDLE;
            busy_q  <= 1'b0;
          end
        end
        SEQ_HALT: begin
          if (!start) begin
            state_q  <= SEQ_IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= SEQ_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = pc_q;
  assign pc           = pc_q;
  assign instr_out    = instr_q;
  assign instr_valid  = instr_valid_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign retired_cnt  = retired_q;
  assign exec_timeout = wdog_hit;

endmodule

// File: tb/tb_fpu_fetch_sequencer.sv
// Self-checking bench for fpu_fetch_sequencer: directed scenarios plus
// randomized programs checked against a program-level reference model.
module tb_fpu_fetch_sequencer;

  localparam logic [31:0] HALT_WORD = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        exec_done = 1'b0;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic [15:0] retired_cnt;
  logic        exec_timeout;

  logic        start8 = 1'b0;
  logic        rvalid8 = 1'b0;
  logic [31:0] rdata8 = '0;
  logic        done8 = 1'b0;
  logic        memReq8;
  logic [7:0]  memAddr8;
  logic [31:0] instrOut8;
  logic        instrValid8;
  logic [7:0]  pc8;
  logic        busy8;
  logic        halted8;
  logic [1:0]  retired8;
  logic        timeout8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fpu_fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .retired_cnt  (retired_cnt),
    .exec_timeout (exec_timeout)
  );

  fpu_fetch_sequencer #(
    .PC_W     (8),
    .RESET_PC (8'hFC),
    .CNT_W    (2)
  ) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .mem_req      (memReq8),
    .mem_addr     (memAddr8),
    .mem_rvalid   (rvalid8),
    .mem_rdata    (rdata8),
    .instr_out    (instrOut8),
    .instr_valid  (instrValid8),
    .exec_done    (done8),
    .pc           (pc8),
    .busy         (busy8),
    .halted       (halted8),
    .retired_cnt  (retired8),
    .exec_timeout (timeout8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    mem_rvalid = 1'b0;
    exec_done = 1'b0;
    start8 = 1'b0;
    rvalid8 = 1'b0;
    done8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Memory responder: waits for a request, holds rvalid low for 'waits'
  // cycles, then returns 'word'. Leaves the DUT one cycle past the response.
  task automatic serve_fetch(input logic [31:0] word, input int waits,
                             output bit ok, output logic [31:0] addr,
                             output bit stable);
    ok = 1'b0;
    stable = 1'b1;
    addr = 'x;
    for (int i = 0; i < 50; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    addr = mem_addr;
    for (int i = 0; i < waits; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_addr !== addr || busy !== 1'b1) stable = 1'b0;
    end
    mem_rvalid = 1'b1;
    mem_rdata = word;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
  endtask

  // Execution unit: entered in the DECODE cycle; signals done after 'delay'
  // idle EXEC cycles and records decode pulses and busy along the way.
  task automatic serve_exec(input int delay, output int pulses,
                            output logic [31:0] seen, output bit busyOk);
    pulses = 0;
    busyOk = 1'b1;
    seen = '0;
    if (instr_valid === 1'b1) begin
      pulses++;
      seen = instr_out;
    end
    if (busy !== 1'b1) busyOk = 1'b0;
    tick();
    for (int i = 0; i < delay; i++) begin
      if (instr_valid === 1'b1) pulses++;
      if (busy !== 1'b1) busyOk = 1'b0;
      tick();
    end
    if (instr_valid === 1'b1) pulses++;
    if (busy !== 1'b1) busyOk = 1'b0;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ones;
    do_reset();
    ones = {mem_req, instr_valid, busy, halted, exec_timeout, 27'd0};
    compared++;
    if (ones !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", ones[31:27]);
    end
    compared++;
    if (pc !== 32'd0 || instr_out !== 32'd0 || retired_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got pc=%h instr=%h ret=%0d expected 0/0/0",
               pc, instr_out, retired_cnt);
    end
    tick();
    tick();
    compared++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_hold: got req=%b busy=%b expected 0/0", mem_req, busy);
    end
  endtask

  task automatic test_basic_run();
    bit ok, stable, busyOk;
    logic [31:0] addr, seen;
    logic [31:0] w2;
    int pulses;
    do_reset();
    start = 1'b1;
    serve_fetch(32'h00B5_0553, 0, ok, addr, stable);
    compared++;
    if (!ok || addr !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL basic_addr: got ok=%b addr=%h expected 1/0", ok, addr);
    end
    serve_exec(0, pulses, seen, busyOk);
    compared++;
    if (pulses !== 1 || seen !== 32'h00B5_0553) begin
      mismatched++;
      $display("[TB] FAIL basic_decode: got pulses=%0d instr=%h expected 1/00b50553",
               pulses, seen);
    end
    compared++;
    if (pc !== 32'd4 || retired_cnt !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL basic_retire: got pc=%h ret=%0d expected 4/1", pc, retired_cnt);
    end
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin
      mismatched++;
      $display("[TB] FAIL basic_next_req: got req=%b addr=%h expected 1/4", mem_req, mem_addr);
    end
    // Dropping start mid-fetch must still complete the fetch.
    start = 1'b0;
    w2 = 32'h1234_5678;
    serve_fetch(w2, 1, ok, addr, stable);
    serve_exec(0, pulses, seen, busyOk);
    compared++;
    if (!ok || seen !== w2 || busy !== 1'b0 || retired_cnt !== 16'd2 || pc !== 32'd8) begin
      mismatched++;
      $display("[TB] FAIL basic_stop: got instr=%h busy=%b ret=%0d pc=%h expected %h/0/2/8",
               seen, busy, retired_cnt, pc, w2);
    end
    compared++;
    if (exec_timeout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL no_timeout: got %b expected 0", exec_timeout);
    end
  endtask

  task automatic test_wait_states();
    bit ok, stable, busyOk;
    logic [31:0] addr, seen;
    int pulses;
    do_reset();
    start = 1'b1;
    serve_fetch(32'hCAFE_0001, 3, ok, addr, stable);
    compared++;
    if (!ok || !stable || addr !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL wait_fetch: got ok=%b stable=%b addr=%h expected 1/1/0",
               ok, stable, addr);
    end
    start = 1'b0;
    serve_exec(10, pulses, seen, busyOk);
    compared++;
    if (pulses !== 1 || !busyOk || seen !== 32'hCAFE_0001) begin
      mismatched++;
      $display("[TB] FAIL wait_exec: got pulses=%0d busy_ok=%b instr=%h expected 1/1/cafe0001",
               pulses, busyOk, seen);
    end
    compared++;
    if (busy !== 1'b0 || retired_cnt !== 16'd1 || pc !== 32'd4) begin
      mismatched++;
      $display("[TB] FAIL wait_done: got busy=%b ret=%0d pc=%h expected 0/1/4",
               busy, retired_cnt, pc);
    end
  endtask

  task automatic test_halt();
    bit ok, stable, busyOk;
    logic [31:0] addr, seen;
    int pulses;
    int sawValid;
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      serve_fetch(32'hA000_0000 + 32'(k), $urandom_range(0, 2), ok, addr, stable);
      serve_exec($urandom_range(0, 3), pulses, seen, busyOk);
    end
    serve_fetch(HALT_WORD, 1, ok, addr, stable);
    compared++;
    if (!ok || addr !== 32'd8) begin
      mismatched++;
      $display("[TB] FAIL halt_addr: got ok=%b addr=%h expected 1/8", ok, addr);
    end
    compared++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 32'd0 || retired_cnt !== 16'd2) begin
      mismatched++;
      $display("[TB] FAIL halt_state: got halted=%b busy=%b pc=%h ret=%0d expected 1/0/0/2",
               halted, busy, pc, retired_cnt);
    end
    sawValid = (instr_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (instr_valid === 1'b1 || halted !== 1'b1) sawValid++;
    end
    compared++;
    if (sawValid !== 0) begin
      mismatched++;
      $display("[TB] FAIL halt_hold: got %0d bad cycles expected 0", sawValid);
    end
    start = 1'b0;
    tick();
    compared++;
    if (halted !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL halt_exit: got halted=%b busy=%b req=%b expected 0/0/0",
               halted, busy, mem_req);
    end
    start = 1'b1;
    tick();
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL halt_restart: got req=%b addr=%h expected 1/0", mem_req, mem_addr);
    end
  endtask

  task automatic test_stop();
    bit ok, stable;
    logic [31:0] addr;
    int badIdle;
    do_reset();
    start = 1'b1;
    serve_fetch(32'h0000_0553, 0, ok, addr, stable);
    tick();
    tick();
    tick();
    start = 1'b0;
    tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    compared++;
    if (busy !== 1'b0 || retired_cnt !== 16'd1 || mem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stop_idle: got busy=%b ret=%0d req=%b expected 0/1/0",
               busy, retired_cnt, mem_req);
    end
    badIdle = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_req !== 1'b0 || instr_valid !== 1'b0) badIdle++;
    end
    compared++;
    if (badIdle !== 0) begin
      mismatched++;
      $display("[TB] FAIL stop_stays_idle: got %0d bad cycles expected 0", badIdle);
    end
  endtask

  task automatic test_wrap();
    int fetches;
    logic [7:0] expAddr;
    logic [1:0] expRet;
    do_reset();
    rdata8 = 32'h00B5_0553;
    rvalid8 = 1'b1;
    done8 = 1'b1;
    start8 = 1'b1;
    fetches = 0;
    for (int cyc = 0; cyc < 40 && fetches < 6; cyc++) begin
      tick();
      if (memReq8 === 1'b1) begin
        expAddr = 8'hFC + 8'(4 * fetches);
        expRet = 2'(fetches);
        compared++;
        if (memAddr8 !== expAddr || retired8 !== expRet) begin
          mismatched++;
          $display("[TB] FAIL wrap_fetch%0d: got addr=%h ret=%0d expected %h/%0d",
                   fetches, memAddr8, retired8, expAddr, expRet);
        end
        fetches++;
      end
    end
    compared++;
    if (fetches !== 6) begin
      mismatched++;
      $display("[TB] FAIL wrap_count: got %0d fetches expected 6", fetches);
    end
    start8 = 1'b0;
    rvalid8 = 1'b0;
    done8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok, stable;
    logic [31:0] addr;
    int bad;
    do_reset();
    start = 1'b1;
    serve_fetch(32'h5555_AAAA, 0, ok, addr, stable);
    tick();
    tick();
    rst = 1'b1;
    start = 1'b0;
    tick();
    compared++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
        exec_timeout !== 1'b0 || instr_out !== 32'd0 || pc !== 32'd0 || retired_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid: got req=%b v=%b busy=%b pc=%h ret=%0d expected all 0",
               mem_req, instr_valid, busy, pc, retired_cnt);
    end
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    exec_done = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0 ||
          pc !== 32'd0 || retired_cnt !== 16'd0) bad++;
    end
    mem_rvalid = 1'b0;
    exec_done = 1'b0;
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL stale_rvalid: got %0d bad cycles expected 0", bad);
    end
  endtask

  // Program-level model: each non-halt word is decoded once at pc, pc moves
  // on by 4 and one retire follows; the halt word returns pc to 0.
  task automatic test_random_programs();
    bit ok, stable, busyOk;
    logic [31:0] addr, seen;
    logic [31:0] words [0:8];
    logic [31:0] expPc;
    int expRet, n, pulses;
    for (int prog = 0; prog < 4; prog++) begin
      do_reset();
      n = $urandom_range(2, 8);
      for (int i = 0; i < n; i++) begin
        words[i] = $urandom;
        if (words[i] == HALT_WORD) words[i] = 32'h0000_0011;
      end
      words[n] = HALT_WORD;
      expPc = 32'd0;
      expRet = 0;
      start = 1'b1;
      for (int i = 0; i <= n; i++) begin
        serve_fetch(words[i], $urandom_range(0, 3), ok, addr, stable);
        compared++;
        if (!ok || addr !== expPc) begin
          mismatched++;
          $display("[TB] FAIL rand%0d_addr%0d: got ok=%b addr=%h expected 1/%h",
                   prog, i, ok, addr, expPc);
        end
        if (i < n) begin
          expPc = expPc + 32'd4;
          serve_exec($urandom_range(0, 4), pulses, seen, busyOk);
          expRet++;
          compared++;
          if (pulses !== 1 || seen !== words[i] || pc !== expPc ||
              retired_cnt !== 16'(expRet) || !busyOk) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_insn%0d: got pulses=%0d instr=%h pc=%h ret=%0d expected 1/%h/%h/%0d",
                     prog, i, pulses, seen, pc, retired_cnt, words[i], expPc, expRet);
          end
        end
      end
      compared++;
      if (halted !== 1'b1 || pc !== 32'd0 || retired_cnt !== 16'(n)) begin
        mismatched++;
        $display("[TB] FAIL rand%0d_halt: got halted=%b pc=%h ret=%0d expected 1/0/%0d",
                 prog, halted, pc, retired_cnt, n);
      end
      start = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_wait_states();
    test_halt();
    test_stop();
    test_wrap();
    test_reset_mid();
    test_random_programs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fpu_fetch_sequencer.md
Name: fpu_fetch_sequencer

Overview:
- Parametrised next-generation fetch/decode/execute sequencer for the single-precision FPU core.
- Fetches instruction words from the instruction memory over a req/rvalid handshake and supports variable memory latency.
- Presents each instruction to the FPU decode for exactly one cycle, then waits for a done handshake from the (possibly multi-cycle) execution unit.
- Adds over the previous generation: configurable widths, reset vector and halt opcode; a dedicated HALT state; and a retired-instruction counter.

Parameters:
- PC_W, 32: program counter and memory address width.
- INSN_W, 32: instruction width.
- PC_INC, 4: PC increment per fetched instruction.
- RESET_PC, 0: PC value after reset and after a halt.
- HALT_INSN, 32'h00000010: instruction encoding that halts the sequencer.
- CNT_W, 16: retired-instruction counter width.
- WDOG_CYCLES, 1024: watchdog limit in EXEC. Used only with FPU_SEQ_WDOG_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; 1 = run program.
- mem_req  out  1  fetch request.
- mem_addr  out  PC_W  fetch address.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  INSN_W  read data.
- instr_out  out  INSN_W  instruction to decode.
- instr_valid  out  1  instr_out valid (one-cycle pulse).
- exec_done  in  1  execution unit finished the current instruction.
- pc  out  PC_W  current PC.
- busy  out  1  state is not IDLE and not HALT.
- halted  out  1  state is HALT.
- retired_cnt  out  CNT_W  number of completed instructions.
- exec_timeout  out  1  watchdog pulse; tied 0 without FPU_SEQ_WDOG_EN.

Behaviour:
- Reset (rst=1 at a clk edge) dominates every other input.
  - state=IDLE, pc=RESET_PC, retired_cnt=0.
  - All 1-bit outputs are 0; instr_out=0.
  - The internal instruction register is cleared.
- States: IDLE, FETCH, DECODE, EXEC, HALT (3-bit encoding).
- IDLE:
  - start=1 -> FETCH on the next cycle.
  - Otherwise remain in IDLE.
- FETCH:
  - mem_req=1 and mem_addr=pc, held stable until mem_rvalid.
  - On mem_rvalid=1, mem_rdata is latched.
  - If mem_rdata==HALT_INSN: go to HALT and set pc<=RESET_PC.
  - Otherwise: go to DECODE and set pc<=pc+PC_INC, modulo 2^PC_W (PC_W'hFFFFFFFC+4 wraps to 0).
  - mem_req deasserts in the cycle after rvalid.
  - Minimum fetch latency is 1 cycle (rvalid may arrive in the first FETCH cycle).
  - start falling during FETCH does not abort the fetch.
- DECODE:
  - Lasts exactly 1 cycle.
  - instr_valid=1 and instr_out = latched instruction; then go to EXEC.
  - Outside DECODE, instr_out=0 and instr_valid=0.
- EXEC:
  - Wait for exec_done=1. exec_done is sampled only in EXEC and ignored elsewhere.
  - If exec_done=1 and start=1 in the same cycle: retired_cnt++ (wraps at 2^CNT_W) and go to FETCH.
  - If exec_done=1 and start=0: retired_cnt++ and go to IDLE.
  - exec_done may be asserted in the first EXEC cycle, which gives a single-cycle op.
- HALT:
  - Stay in HALT while start=1.
  - start=0 -> IDLE.
  - retired_cnt is held; it is not incremented by the halt instruction.
- mem_rvalid outside FETCH, including a stale response after reset, is ignored.
- pc changes only on a FETCH completion or on reset.
- busy=1 in FETCH, DECODE and EXEC.

Optional Feature:
- Macro: FPU_SEQ_WDOG_EN.
- Defined:
  - A cycle counter clears on entry to EXEC and counts while exec_done=0.
  - When it reaches WDOG_CYCLES, exec_timeout pulses for 1 cycle and the sequencer goes to IDLE.
  - retired_cnt is not incremented and pc is unchanged.
  - exec_done arriving in the same cycle as the limit wins: normal retire, no timeout.
- Undefined:
  - No counter logic is built; exec_timeout is tied 0.
  - EXEC waits indefinitely.

Decomposition:
- Shared package fpu_seq_pkg contains:
  - state enum: SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_EXEC, SEQ_HALT;
  - default constants: FPU_RESET_PC, FPU_HALT_INSN, FPU_PC_INC.
- One sub-module: fpu_seq_wdog, the parametrised clear/count/limit counter. It is instantiated only under FPU_SEQ_WDOG_EN.

Test Plan:
- Basic run:
  - Stimulus: reset, then start=1; memory returns 32'h00B50553 with 0-cycle wait at addr 0; exec_done 1 cycle after instr_valid.
  - Response: instr_valid pulses once with instr_out=32'h00B50553; pc=4; retired_cnt=1; the next mem_req has addr 4.
- Wait states and multi-cycle execute:
  - Stimulus: rvalid delayed 3 cycles; exec_done delayed 10 cycles.
  - Response: mem_req and mem_addr stable for all 4 FETCH cycles; instr_valid high exactly 1 cycle; busy=1 throughout.
- Halt:
  - Stimulus: third fetched word = 32'h00000010.
  - Response: halted=1; pc=0; retired_cnt=2; no instr_valid for the halt word. Then start=0 -> IDLE; then start=1 -> fetch from addr 0.
- Stop and wrap:
  - Stimulus: start dropped during EXEC.
  - Response: goes to IDLE after exec_done; retired_cnt increments.
  - Stimulus: PC_W=8 at pc=8'hFC.
  - Response: pc wraps to 0.
- Reset mid-operation and stale response:
  - Stimulus: rst asserted in EXEC; a stale mem_rvalid arrives in IDLE.
  - Response: all outputs 0, pc=RESET_PC; the stale rvalid is ignored.
- Watchdog (FPU_SEQ_WDOG_EN, WDOG_CYCLES=8):
  - Stimulus: exec_done never asserted.
  - Response: exec_timeout pulses in the 8th EXEC cycle; state returns to IDLE; retired_cnt unchanged.
